// File: rtl/cluster_periph_initiator_if.sv
// Purpose : Command / peripheral-bus / response signal bundle for cluster_periph_initiator.
// Ports   : master = the initiator (drives cmd_ready_o, per_*_o, rsp_*_o, busy_o);
//           slave  = its environment (drives commands, grant, bus responses, rsp_ready_i).
interface cluster_periph_initiator_if #(
    parameter int PER_ID_WIDTH = 5
);
    // command side
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [31:0]             cmd_addr_i;
    logic                    cmd_wen_i;
    logic [31:0]             cmd_wdata_i;
    logic [3:0]              cmd_be_i;
    // peripheral request channel
    logic                    per_req_o;
    logic [31:0]             per_add_o;
    logic                    per_wen_o;
    logic [31:0]             per_wdata_o;
    logic [3:0]              per_be_o;
    logic [PER_ID_WIDTH-1:0] per_id_o;
    logic                    per_gnt_i;
    // peripheral response channel
    logic                    per_r_valid_i;
    logic [PER_ID_WIDTH-1:0] per_r_id_i;
    logic [31:0]             per_r_rdata_i;
    logic                    per_r_opc_i;
    // response side
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [31:0]             rsp_rdata_o;
    logic                    rsp_err_o;
    logic                    busy_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_wen_i, cmd_wdata_i, cmd_be_i,
        input  per_gnt_i, per_r_valid_i, per_r_id_i, per_r_rdata_i, per_r_opc_i,
        input  rsp_ready_i,
        output cmd_ready_o,
        output per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_wen_i, cmd_wdata_i, cmd_be_i,
        output per_gnt_i, per_r_valid_i, per_r_id_i, per_r_rdata_i, per_r_opc_i,
        output rsp_ready_i,
        input  cmd_ready_o,
        input  per_req_o, per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/cluster_periph_initiator.sv
// Purpose : Single-outstanding initiator turning one command into one peripheral-bus
//           transaction (req/gnt, then ID-matched r_valid) with a WAIT_RSP timeout.
// Ports   : clk_i, rst_i (async, active-high); bus = cluster_periph_initiator_if.master.
//           Latency: accept->per_req_o 1 cycle, r_valid->rsp_valid_o 1 cycle.
//           Backpressure: cmd_ready_o only in IDLE; response held until rsp_ready_i.
module cluster_periph_initiator #(
    parameter int PER_ID_WIDTH   = 5,
    parameter int MASTER_ID      = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    cluster_periph_initiator_if.master    bus
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    state_t         r_state;
    logic [CNT_W-1:0] r_cnt;

    logic           r_cmd_ready;
    logic           r_per_req;
    logic [31:0]    r_per_add;
    logic           r_per_wen;
    logic [31:0]    r_per_wdata;
    logic [3:0]     r_per_be;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_rdata;
    logic           r_rsp_err;
    logic           r_busy;

    logic           w_rsp_hit;
    logic           w_timeout;

    assign w_rsp_hit = bus.per_r_valid_i && (bus.per_r_id_i == PER_ID_WIDTH'(MASTER_ID));
    assign w_timeout = TIMEOUT_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_per_req   <= 1'b0;
            r_per_add   <= 32'h0;
            r_per_wen   <= 1'b1;
            r_per_wdata <= 32'h0;
            r_per_be    <= 4'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        // The per_* registers double as the command holding registers,
                        // so they keep their value after the request completes.
                        r_per_add   <= bus.cmd_addr_i;
                        r_per_wen   <= bus.cmd_wen_i;
                        r_per_wdata <= bus.cmd_wdata_i;
                        r_per_be    <= bus.cmd_be_i;
                        r_per_req   <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // No timeout while waiting for grant.
                    if (bus.per_gnt_i) begin
                        r_per_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    // A matching response beats a same-cycle timeout.
                    if (w_rsp_hit) begin
                        r_rsp_rdata <= bus.per_r_rdata_i;
                        r_rsp_err   <= bus.per_r_opc_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.per_req_o   = r_per_req;
    assign bus.per_add_o   = r_per_add;
    assign bus.per_wen_o   = r_per_wen;
    assign bus.per_wdata_o = r_per_wdata;
    assign bus.per_be_o    = r_per_be;
    assign bus.per_id_o    = PER_ID_WIDTH'(MASTER_ID);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_cluster_periph_initiator.sv
module tb_cluster_periph_initiator;

    localparam int IDW = 5;
    localparam int MID = 3;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cluster_periph_initiator_if #(.PER_ID_WIDTH(IDW)) bus ();

    cluster_periph_initiator #(
        .PER_ID_WIDTH   (IDW),
        .MASTER_ID      (MID),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [32:0] exp_q[$];   // {err, rdata}
    bit force_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // response consumer with random backpressure
    initial begin
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready_i = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor / scoreboard
    initial begin
        logic [32:0] held;
        logic [32:0] e;
        bit held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) chk("rsp_valid_hold", 64'(bus.rsp_valid_o), 64'(1));
                if (bus.rsp_valid_o) begin
                    chk("cmd_ready_in_resp", 64'(bus.cmd_ready_o), 64'(0));
                    if (held_v) chk("rsp_data_hold", 64'({bus.rsp_err_o, bus.rsp_rdata_o}), 64'(held));
                    if (bus.rsp_ready_i) begin
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_rsp");
                        end else begin
                            e = exp_q.pop_front();
                            chk("rsp", 64'({bus.rsp_err_o, bus.rsp_rdata_o}), 64'(e));
                        end
                        held_v = 1'b0;
                    end else begin
                        held   = {bus.rsp_err_o, bus.rsp_rdata_o};
                        held_v = 1'b1;
                    end
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_per_req"},   64'(bus.per_req_o),   64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid_o), 64'(0));
        chk({tag, "_rsp_err"},   64'(bus.rsp_err_o),   64'(0));
        chk({tag, "_busy"},      64'(bus.busy_o),      64'(0));
        chk({tag, "_per_add"},   64'(bus.per_add_o),   64'(0));
        chk({tag, "_per_wdata"}, 64'(bus.per_wdata_o), 64'(0));
        chk({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata_o), 64'(0));
        chk({tag, "_per_be"},    64'(bus.per_be_o),    64'(0));
        chk({tag, "_per_wen"},   64'(bus.per_wen_o),   64'(1));
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'(1));
    endtask

    // Issue one command and play the peripheral. Called at posedge+1.
    // rsp_k: WAIT_RSP cycle index at which the matching response is driven (>= TO: never).
    // bad_k: WAIT_RSP cycle index of a wrong-ID response (-1: none).
    task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                           input logic [3:0] be, input int gnt_dly, input int rsp_k,
                           input int bad_k, input logic [31:0] rdata, input logic opc,
                           input bit hold5, input bit expect_rsp);
        int n;
        if (expect_rsp) begin
            if (rsp_k < TO) exp_q.push_back({opc, rdata});
            else            exp_q.push_back({1'b1, 32'h0});
        end
        if (hold5) force_low = 1'b1;
        n = 0;
        while (!bus.cmd_ready_o && n < 50) begin step(); n++; end
        if (!bus.cmd_ready_o) begin fail_now("cmd_ready_wait"); return; end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = addr;
        bus.cmd_wen_i   = wen;
        bus.cmd_wdata_i = wdata;
        bus.cmd_be_i    = be;
        step();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = $urandom;
        bus.cmd_wdata_i = $urandom;
        bus.cmd_be_i    = 4'($urandom);
        bus.cmd_wen_i   = 1'($urandom);
        for (int g = 0; g <= gnt_dly; g++) begin
            chk("req_high",   64'(bus.per_req_o),   64'(1));
            chk("req_add",    64'(bus.per_add_o),   64'(addr));
            chk("req_wdata",  64'(bus.per_wdata_o), 64'(wdata));
            chk("req_wen_be_id", 64'({bus.per_wen_o, bus.per_be_o, bus.per_id_o}),
                64'({wen, be, IDW'(MID)}));
            chk("req_cmd_ready", 64'(bus.cmd_ready_o), 64'(0));
            bus.per_gnt_i = (g == gnt_dly);
            step();
        end
        bus.per_gnt_i = 1'b0;
        for (int k = 0; k < TO; k++) begin
            chk("wait_req_low",   64'(bus.per_req_o),   64'(0));
            chk("wait_rsp_low",   64'(bus.rsp_valid_o), 64'(0));
            chk("wait_busy",      64'(bus.busy_o),      64'(1));
            if (k == bad_k) begin
                bus.per_r_valid_i = 1'b1;
                bus.per_r_id_i    = IDW'(MID + 1);
                bus.per_r_rdata_i = $urandom;
                bus.per_r_opc_i   = 1'($urandom);
            end else if (k == rsp_k) begin
                bus.per_r_valid_i = 1'b1;
                bus.per_r_id_i    = IDW'(MID);
                bus.per_r_rdata_i = rdata;
                bus.per_r_opc_i   = opc;
            end
            step();
            bus.per_r_valid_i = 1'b0;
            if (k == rsp_k) break;
        end
        chk("rsp_latency", 64'(bus.rsp_valid_o), 64'(1));
        if (rsp_k >= TO) begin
            // late matching response after timeout must be ignored
            bus.per_r_valid_i = 1'b1;
            bus.per_r_id_i    = IDW'(MID);
            bus.per_r_rdata_i = 32'hFACE_0000 | 32'($urandom_range(1, 255));
            bus.per_r_opc_i   = 1'b0;
            step();
            bus.per_r_valid_i = 1'b0;
        end
        if (hold5) begin
            repeat (5) step();
            chk("hold5_valid", 64'(bus.rsp_valid_o), 64'(1));
            force_low = 1'b0;
        end
        n = 0;
        while (bus.busy_o && n < 100) begin step(); n++; end
        if (bus.busy_o) fail_now("busy_wait");
        else chk("idle_cmd_ready", 64'(bus.cmd_ready_o), 64'(1));
    endtask

    initial begin
        int rk, bk, lim;
        #(500us);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rk, bk, lim;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_addr_i    = '0;
        bus.cmd_wen_i     = 1'b0;
        bus.cmd_wdata_i   = '0;
        bus.cmd_be_i      = '0;
        bus.per_gnt_i     = 1'b0;
        bus.per_r_valid_i = 1'b0;
        bus.per_r_id_i    = '0;
        bus.per_r_rdata_i = '0;
        bus.per_r_opc_i   = 1'b0;
        repeat (3) step();
        check_reset("por");
        rst = 1'b0;
        step();

        // write, zero-wait grant, response next cycle
        run_txn(32'h000, 1'b0, 32'h1, 4'hF, 0, 0, -1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1);
        // read, grant after 3 cycles
        run_txn(32'h040, 1'b1, 32'h0, 4'hF, 3, 0, -1, 32'h1C00_0000, 1'b0, 1'b0, 1'b1);
        // read, no response -> timeout
        run_txn(32'h080, 1'b1, 32'h0, 4'hF, 0, TO + 2, -1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        // wrong-ID response then matching one two cycles later with error
        run_txn(32'h0C0, 1'b1, 32'h0, 4'h3, 1, 2, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
        // response on the last WAIT_RSP cycle beats the timeout
        run_txn(32'h100, 1'b1, 32'h0, 4'hF, 0, TO - 1, -1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);
        // consumer stalls 5 cycles
        run_txn(32'h140, 1'b1, 32'h0, 4'hC, 2, 1, -1, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1);

        // reset mid-transaction: issue command, then reset during WAIT_RSP
        fork
            run_txn(32'h200, 1'b1, 32'h9, 4'hF, 0, TO + 5, -1, 32'h0, 1'b0, 1'b0, 1'b0);
        join_none
        step(); step(); step();   // accept, REQ(grant), now in WAIT_RSP
        disable fork;
        bus.per_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        check_reset("async_rst");
        step();
        check_reset("rst_edge");
        rst = 1'b0;
        bus.per_r_valid_i = 1'b1;
        bus.per_r_id_i    = IDW'(MID);
        bus.per_r_rdata_i = 32'hCAFE_CAFE;
        bus.per_r_opc_i   = 1'b1;
        step();
        bus.per_r_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_rsp", 64'({bus.rsp_valid_o, bus.busy_o}), 64'(0));
            step();
        end

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            rk  = $urandom_range(0, TO + 2);
            lim = (rk < TO) ? rk : TO;
            bk  = (lim > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, lim - 1)) : -1;
            run_txn($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 3), rk, bk, $urandom, 1'($urandom), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                // stray response while idle
                bus.per_r_valid_i = 1'b1;
                bus.per_r_id_i    = IDW'(MID);
                bus.per_r_rdata_i = $urandom;
                bus.per_r_opc_i   = 1'($urandom);
                step();
                bus.per_r_valid_i = 1'b0;
                chk("idle_stray", 64'({bus.rsp_valid_o, bus.busy_o}), 64'(0));
            end
        end

        repeat (5) step();
        if (exp_q.size() != 0) fail_now("responses_missing");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
